// File: rtl/uart_rx_axis_fifo.sv
// uart_rx_axis_fifo: oversampling UART receiver with majority vote, parity/frame/break checks
// and an output FIFO presented as an AXI-Stream master with tready backpressure.
module uart_rx_axis_fifo #(
    parameter int CLK_FREQ      = 96,
    parameter int BIT_RATE      = 115200,
    parameter int OVERSAMPLE    = 16,
    parameter int BIT_PER_WORD  = 8,
    parameter int PARITY_BIT    = 0,
    parameter int STOP_BITS_NUM = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              rx,
    output logic [BIT_PER_WORD-1:0]           m_axis_tdata,
    output logic [2:0]                        m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    input  logic                              overrun_clr,
    output logic                              rx_busy
);
    localparam int BAUD_TICKS = BIT_RATE * OVERSAMPLE;
    localparam int TD_RAW     = (CLK_FREQ * 1000000 + BAUD_TICKS / 2) / BAUD_TICKS;
    localparam int TICK_DIV   = (TD_RAW < 1) ? 1 : TD_RAW;
    localparam int DW = $clog2(TICK_DIV + 1);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(BIT_PER_WORD);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int H  = OVERSAMPLE / 2;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_S0     = TW'(H - 1);
    localparam logic [TW-1:0] T_S1     = TW'(H);
    localparam logic [TW-1:0] T_MID    = TW'(H + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BIT_PER_WORD - 1);
    localparam logic          S_LAST   = 1'(STOP_BITS_NUM - 1);
    localparam logic [CW-1:0] C_FULL   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH, S_WAIT} state_t;

    state_t                  r_state;
    logic [1:0]              r_sync;
    logic                    r_rx_prev, r_s0, r_s1;
    logic [DW-1:0]           r_div;
    logic [TW-1:0]           r_t;
    logic [BIT_PER_WORD-1:0] r_shift;
    logic [BW-1:0]           r_bit;
    logic                    r_stop, r_par_err, r_frame_err, r_zero, r_brk, r_overrun;
    logic [AW-1:0]           r_wp, r_rp;
    logic [CW-1:0]           r_count;
    logic [BIT_PER_WORD+2:0] r_mem [FIFO_DEPTH];

    logic w_rx, w_start, w_tick, w_mid, w_end, w_maj, w_par_exp;
    logic w_valid, w_pop, w_push, w_wr;
    logic [BIT_PER_WORD+2:0] w_head;

    assign w_rx      = r_sync[1];
    assign w_start   = (r_state == S_IDLE) && r_rx_prev && !w_rx;
    assign w_tick    = r_div == DIV_LAST;
    assign w_mid     = w_tick && (r_t == T_MID);
    assign w_end     = w_tick && (r_t == T_LAST);
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_par_exp = (PARITY_BIT == 1) ? ~^r_shift : (PARITY_BIT == 2) ? ^r_shift : (PARITY_BIT == 3);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_div     <= '0;
            r_t       <= '0;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx;
            r_div     <= (w_start || w_tick) ? '0 : r_div + 1'b1;
            r_t       <= w_start ? '0 : !w_tick ? r_t : (r_t == T_LAST) ? '0 : r_t + 1'b1;
            if (w_tick && r_t == T_S0) r_s0 <= w_rx;
            if (w_tick && r_t == T_S1) r_s1 <= w_rx;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit       <= '0;
            r_stop      <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_zero      <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_state     <= S_START;
                    r_bit       <= '0;
                    r_stop      <= 1'b0;
                    r_par_err   <= 1'b0;
                    r_frame_err <= 1'b0;
                    r_zero      <= 1'b1;
                    r_brk       <= 1'b0;
                end
                S_START: if (w_mid && w_maj) r_state <= S_IDLE;
                    else if (w_end) r_state <= S_DATA;
                S_DATA: begin
                    if (w_mid) begin
                        r_shift <= {w_maj, r_shift[BIT_PER_WORD-1:1]};
                        r_zero  <= r_zero & ~w_maj;
                    end
                    if (w_end) begin
                        r_bit <= r_bit + 1'b1;
                        if (r_bit == B_LAST) r_state <= (PARITY_BIT != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: if (w_mid) begin
                    r_par_err <= w_maj != w_par_exp;
                    r_zero    <= r_zero & ~w_maj;
                end else if (w_end) r_state <= S_STOP;
                // The last stop bit hands over at its mid-point so a following start edge is not missed
                S_STOP: if (w_mid) begin
                    if (!w_maj) r_frame_err <= 1'b1;
                    r_zero <= r_zero & ~w_maj;
                    if (r_stop == S_LAST) begin
                        r_state <= S_PUSH;
                        r_brk   <= r_zero & ~w_maj;
                    end
                end else if (w_end) r_stop <= 1'b1;
                S_PUSH: r_state <= r_frame_err ? S_WAIT : S_IDLE;
                S_WAIT: if (w_rx) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_head  = r_mem[r_rp];
    assign w_valid = r_count != '0;
    assign w_pop   = w_valid && m_axis_tready;
    assign w_push  = r_state == S_PUSH;
    assign w_wr    = w_push && ((r_count != C_FULL) || w_pop);

    always_ff @(posedge aclk) begin
        if (w_wr) r_mem[r_wp] <= {r_brk, r_frame_err, r_par_err, r_shift};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count   <= r_count + CW'(w_wr) - CW'(w_pop);
            r_overrun <= (w_push && !w_wr) ? 1'b1 : overrun_clr ? 1'b0 : r_overrun;
        end
    end

    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_valid ? w_head[BIT_PER_WORD-1:0] : '0;
    assign m_axis_tuser  = w_valid ? w_head[BIT_PER_WORD+2:BIT_PER_WORD] : '0;
    assign fifo_count    = r_count;
    assign overrun       = r_overrun;
    assign rx_busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// tb_uart_rx_axis_fifo: directed and randomized frames into an 8N1 and an 8E1 receiver,
// beats checked against expectations derived from the bits put on the line.
module tb_uart_rx_axis_fifo;
    localparam int BIT = 96;

    logic       aclk = 1'b0, areset, clr;
    logic       rx_n, rdy_n, v_n, ov_n, busy_n;
    logic [7:0] d_n;
    logic [2:0] usr_n;
    logic [4:0] cnt_n;
    logic       rx_e, rdy_e, v_e, ov_e, busy_e;
    logic [7:0] d_e;
    logic [2:0] usr_e;
    logic [4:0] cnt_e;

    int  total = 0, bad = 0;
    time t_rise, t0;

    uart_rx_axis_fifo #(.CLK_FREQ(96), .BIT_RATE(1000000), .OVERSAMPLE(16), .BIT_PER_WORD(8),
                        .PARITY_BIT(0), .STOP_BITS_NUM(1), .FIFO_DEPTH(16)) u_n (
        .aclk(aclk), .areset(areset), .rx(rx_n), .m_axis_tdata(d_n), .m_axis_tuser(usr_n),
        .m_axis_tvalid(v_n), .m_axis_tready(rdy_n), .fifo_count(cnt_n), .overrun(ov_n),
        .overrun_clr(clr), .rx_busy(busy_n));

    uart_rx_axis_fifo #(.CLK_FREQ(96), .BIT_RATE(1000000), .OVERSAMPLE(16), .BIT_PER_WORD(8),
                        .PARITY_BIT(2), .STOP_BITS_NUM(1), .FIFO_DEPTH(16)) u_e (
        .aclk(aclk), .areset(areset), .rx(rx_e), .m_axis_tdata(d_e), .m_axis_tuser(usr_e),
        .m_axis_tvalid(v_e), .m_axis_tready(rdy_e), .fifo_count(cnt_e), .overrun(ov_e),
        .overrun_clr(clr), .rx_busy(busy_e));

    always #5 aclk = ~aclk;
    always @(posedge v_n) t_rise = $time;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic line(input bit w, input logic v, input int n);
        if (w) rx_e = v; else rx_n = v;
        repeat (n) @(negedge aclk);
    endtask

    // w selects the even-parity receiver, which also gets a parity bit on the line
    task automatic send(input bit w, input logic [7:0] d, input logic pb, input logic sb);
        line(w, 1'b0, BIT);
        for (int i = 0; i < 8; i++) line(w, d[i], BIT);
        if (w) line(w, pb, BIT);
        line(w, sb, BIT);
        line(w, 1'b1, BIT);
    endtask

    function automatic logic [2:0] model(input bit w, input logic [7:0] d, input logic pb, input logic sb);
        logic pe, fe, brk;
        pe  = w && (pb != ^d);
        fe  = !sb;
        brk = (d == 8'h00) && !sb && (!w || !pb);
        return {brk, fe, pe};
    endfunction

    task automatic expect_beat(input bit w, input string tag, input logic [7:0] ed, input logic [2:0] eu);
        int n = 0;
        while (!(w ? v_e : v_n) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_valid"}, 32'(w ? v_e : v_n), 1);
        chk({tag, "_data"}, 32'(w ? d_e : d_n), 32'(ed));
        chk({tag, "_user"}, 32'(w ? usr_e : usr_n), 32'(eu));
        if (w) rdy_e = 1'b1; else rdy_n = 1'b1;
        @(negedge aclk);
        rdy_e = 1'b0;
        rdy_n = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       b;
        int         n;
        areset = 1'b1; clr = 1'b0;
        rx_n = 1'b1; rx_e = 1'b1; rdy_n = 1'b0; rdy_e = 1'b0;
        repeat (4) @(negedge aclk);
        chk("rst_valid", 32'(v_n), 0);
        chk("rst_data", 32'(d_n), 0);
        chk("rst_user", 32'(usr_n), 0);
        chk("rst_count", 32'(cnt_n), 0);
        chk("rst_overrun", 32'(ov_n), 0);
        chk("rst_busy", 32'(busy_n), 0);
        areset = 1'b0;
        repeat (4) @(negedge aclk);

        t0 = $time;
        send(0, 8'hA5, 1'b0, 1'b1);
        chk("t1_latency", 32'(((t_rise - t0) / 10 >= 915) && ((t_rise - t0) / 10 <= 940)), 1);
        chk("t1_overrun", 32'(ov_n), 0);
        expect_beat(0, "t1", 8'hA5, 3'b000);

        send(1, 8'h03, 1'b1, 1'b1);
        expect_beat(1, "t2_bad_par", 8'h03, 3'b001);
        send(1, 8'h03, 1'b0, 1'b1);
        expect_beat(1, "t2_good_par", 8'h03, 3'b000);

        line(0, 1'b0, 20);
        chk("t3_started", 32'(busy_n), 1);
        rx_n = 1'b1;
        n = 0;
        while (busy_n && n < BIT) begin
            @(negedge aclk);
            n++;
        end
        chk("t3_busy", 32'(busy_n), 0);
        line(0, 1'b1, BIT);
        chk("t3_count", 32'(cnt_n), 0);

        send(0, 8'h55, 1'b0, 1'b0);
        expect_beat(0, "t4_frame", 8'h55, 3'b010);
        d = 8'($urandom);
        send(0, d, 1'b0, 1'b1);
        expect_beat(0, "t4_next", d, 3'b000);

        line(0, 1'b0, 20 * BIT);
        line(0, 1'b1, BIT);
        expect_beat(0, "t5_break", 8'h00, 3'b110);
        repeat (300) @(negedge aclk);
        chk("t5_count", 32'(cnt_n), 0);
        chk("t5_busy", 32'(busy_n), 0);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            b = ($urandom_range(0, 3) != 0);
            send(0, d, 1'b0, b);
            expect_beat(0, "rnd_n", d, model(0, d, 1'b0, b));
        end
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            b = 1'($urandom_range(0, 1));
            send(1, d, b, 1'b1);
            expect_beat(1, "rnd_e", d, model(1, d, b, 1'b1));
        end

        for (int i = 0; i < 17; i++) send(0, 8'(i), 1'b0, 1'b1);
        chk("t6_full", 32'(cnt_n), 16);
        chk("t6_overrun", 32'(ov_n), 1);
        for (int i = 0; i < 16; i++) expect_beat(0, "t6_drain", 8'(i), 3'b000);
        chk("t6_empty", 32'(cnt_n), 0);
        chk("t6_valid", 32'(v_n), 0);
        chk("t6_sticky", 32'(ov_n), 1);
        clr = 1'b1;
        @(negedge aclk);
        clr = 1'b0;
        chk("t6_clr", 32'(ov_n), 0);

        line(0, 1'b0, BIT);
        line(0, 1'b1, 4 * BIT);
        areset = 1'b1;
        @(negedge aclk);
        chk("abort_busy", 32'(busy_n), 0);
        chk("abort_count", 32'(cnt_n), 0);
        areset = 1'b0;
        line(0, 1'b1, 10 * BIT);
        chk("abort_nowrite", 32'(cnt_n), 0);
        chk("abort_idle", 32'(busy_n), 0);
        send(0, 8'h3C, 1'b0, 1'b1);
        expect_beat(0, "abort_after", 8'h3C, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
